// File: rtl/adv7513_cfg_pkg.sv
// Shared definitions for the ADV7513 bring-up sequencer: FSM encoding,
// interrupt-clear defaults and the layout of a configuration ROM word.
package adv7513_cfg_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [2:0] S_WAIT  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_BUSY  = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_FAIL  = 3'd5;

    localparam logic [7:0] INT_CLR_REG_DEF = 8'h96;
    localparam logic [7:0] INT_CLR_VAL_DEF = 8'hC0;

    // ROM word is {reg_addr, data}
    localparam int unsigned CFG_W        = 16;
    localparam int unsigned CFG_REG_MSB  = 15;
    localparam int unsigned CFG_REG_LSB  = 8;
    localparam int unsigned CFG_DATA_MSB = 7;
    localparam int unsigned CFG_DATA_LSB = 0;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] data;
    } cfg_word_t;

    function automatic cfg_word_t cfg_unpack(input logic [CFG_W-1:0] word);
        cfg_word_t w;
        w.reg_addr = word[CFG_REG_MSB:CFG_REG_LSB];
        w.data     = word[CFG_DATA_MSB:CFG_DATA_LSB];
        return w;
    endfunction

endpackage

// File: rtl/int_sync_edge.sv
// Two-flop synchroniser for an asynchronous status pin with a single-cycle
// falling-edge pulse taken from the synchronised level.
module int_sync_edge #(
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic fall_c
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= IDLE_LEVEL;
            sync_q <= IDLE_LEVEL;
            prev_q <= IDLE_LEVEL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // Combinational so the FSM can act on the edge in the following cycle
    assign fall_c = prev_q & ~sync_q;

endmodule

// File: rtl/adv7513_cfg_sequencer.sv
// ADV7513 bring-up sequencer: power-up wait, ROM walk through a req/done
// I2C write master with NACK retries, and re-configuration on HDMI_INT.
module adv7513_cfg_sequencer
    import adv7513_cfg_pkg::*;
#(
    parameter int unsigned NUM_OF_CONFIG  = 14,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned STARTUP_CYCLES = 50000,
    parameter int unsigned RETRY_GAP      = 250,
    parameter int unsigned MAX_RETRY      = 3,
    parameter logic [7:0]  INT_CLR_REG    = INT_CLR_REG_DEF,
    parameter logic [7:0]  INT_CLR_VAL    = INT_CLR_VAL_DEF
) (
    input  logic                  CLK_I2C,
    input  logic                  RST_n,
    input  logic                  HDMI_INT,
    input  logic [15:0]           CONFIG,
    output logic [ADDR_WIDTH-1:0] config_addr,
    output logic                  wr_req,
    output logic [7:0]            wr_addr,
    output logic [7:0]            wr_data,
    input  logic                  wr_done,
    input  logic                  wr_nack,
    output logic                  ready,
    output logic                  error
);

    // One counter serves both the startup wait and the retry gap
    localparam int unsigned CNT_MAX = (STARTUP_CYCLES > RETRY_GAP) ? STARTUP_CYCLES : RETRY_GAP;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [STATE_W-1:0]    state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] index_q, index_d;
    logic [RETRY_W-1:0]    retry_q, retry_d;
    logic                  clr_phase_q, clr_phase_d;
    logic                  int_pending_q, int_pending_d;
    logic                  wr_req_q, wr_req_d;
    logic [7:0]            wr_addr_q, wr_addr_d;
    logic [7:0]            wr_data_q, wr_data_d;
    logic                  ready_q, ready_d;
    logic                  error_q, error_d;

    logic                  int_fall_c;
    logic                  int_event_c;
    logic                  last_entry_c;
    cfg_word_t             cfg_c;

    int_sync_edge #(
        .IDLE_LEVEL (1'b1)
    ) u_int_sync (
        .clk_i   (CLK_I2C),
        .rst_ni  (RST_n),
        .async_i (HDMI_INT),
        .fall_c  (int_fall_c)
    );

    assign int_event_c  = int_pending_q | int_fall_c;
    assign last_entry_c = (index_q == ADDR_WIDTH'(NUM_OF_CONFIG - 1));
    assign cfg_c        = cfg_unpack(CONFIG);

    always_ff @(posedge CLK_I2C or negedge RST_n) begin
        if (!RST_n) begin
            state_q       <= S_WAIT;
            cnt_q         <= '0;
            index_q       <= '0;
            retry_q       <= '0;
            clr_phase_q   <= 1'b0;
            int_pending_q <= 1'b0;
            wr_req_q      <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            ready_q       <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            index_q       <= index_d;
            retry_q       <= retry_d;
            clr_phase_q   <= clr_phase_d;
            int_pending_q <= int_pending_d;
            wr_req_q      <= wr_req_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            ready_q       <= ready_d;
            error_q       <= error_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        index_d       = index_q;
        retry_d       = retry_q;
        clr_phase_d   = clr_phase_q;
        int_pending_d = int_event_c;
        wr_req_d      = wr_req_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        ready_d       = ready_q;
        error_d       = error_q;

        case (state_q)
            S_WAIT: begin
                // The full sequence runs after power-up, so early events are dropped
                int_pending_d = 1'b0;
                if (cnt_q == CNT_W'(STARTUP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_ISSUE: begin
                wr_req_d = 1'b1;
                if (clr_phase_q) begin
                    wr_addr_d = INT_CLR_REG;
                    wr_data_d = INT_CLR_VAL;
                end else begin
                    wr_addr_d = cfg_c.reg_addr;
                    wr_data_d = cfg_c.data;
                end
                state_d = S_BUSY;
            end

            S_BUSY: begin
                if (wr_done) begin
                    wr_req_d = 1'b0;
                    if (int_event_c) begin
                        // Abandon the walk; the clear write restarts it from index 0
                        clr_phase_d   = 1'b1;
                        retry_d       = '0;
                        int_pending_d = 1'b0;
                        state_d       = S_ISSUE;
                    end else if (!wr_nack) begin
                        retry_d = '0;
                        if (clr_phase_q) begin
                            clr_phase_d = 1'b0;
                            index_d     = '0;
                            state_d     = S_ISSUE;
                        end else if (last_entry_c) begin
                            ready_d = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            index_d = index_q + ADDR_WIDTH'(1);
                            state_d = S_ISSUE;
                        end
                    end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + RETRY_W'(1);
                        cnt_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_FAIL;
                    end
                end
            end

            S_GAP: begin
                if (cnt_q == CNT_W'(RETRY_GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                    if (int_event_c) begin
                        clr_phase_d   = 1'b1;
                        retry_d       = '0;
                        int_pending_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DONE, S_FAIL: begin
                if (int_event_c) begin
                    ready_d       = 1'b0;
                    error_d       = 1'b0;
                    clr_phase_d   = 1'b1;
                    retry_d       = '0;
                    int_pending_d = 1'b0;
                    state_d       = S_ISSUE;
                end
            end

            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    assign config_addr = index_q;
    assign wr_req      = wr_req_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign ready       = ready_q;
    assign error       = error_q;

endmodule

// File: tb/tb_adv7513_cfg_sequencer.sv
// Scoreboard bench for adv7513_cfg_sequencer: scenarios push the expected
// I2C write stream; a master model pops, checks and answers each request.
module tb_adv7513_cfg_sequencer;

    localparam int unsigned NUM     = 14;
    localparam int unsigned AW      = 4;
    localparam int unsigned STARTUP = 10;
    localparam int unsigned GAP     = 20;
    localparam int unsigned MAXR    = 3;
    localparam int          BUDGET  = 6000;

    logic          CLK_I2C = 1'b0;
    logic          RST_n;
    logic          int_s, int_m;
    logic          HDMI_INT;
    logic [15:0]   CONFIG;
    logic [AW-1:0] config_addr;
    logic          wr_req;
    logic [7:0]    wr_addr, wr_data;
    logic          done_m, done_s, nack_m;
    logic          wr_done, wr_nack;
    logic          ready, error;

    logic [15:0]   rom [NUM];
    int            plan [NUM];

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        bit         nack;
        int         tmode;   // 0 none, 1 relative to previous done, 2 absolute after reset
        bit         rdy;
        bit         err;
        bit         hold;
        bit         irq;
    } exp_t;

    exp_t expq [$];

    int n_cmp  = 0;
    int n_fail = 0;
    int edge_cnt;

    assign HDMI_INT = int_s & int_m;
    assign wr_done  = done_m | done_s;
    assign wr_nack  = nack_m;

    always_comb CONFIG = (32'(config_addr) < NUM) ? rom[config_addr] : 16'h0000;

    always #5 CLK_I2C = ~CLK_I2C;

    always @(posedge CLK_I2C or negedge RST_n) begin
        if (!RST_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    adv7513_cfg_sequencer #(
        .NUM_OF_CONFIG  (NUM),
        .ADDR_WIDTH     (AW),
        .STARTUP_CYCLES (STARTUP),
        .RETRY_GAP      (GAP),
        .MAX_RETRY      (MAXR),
        .INT_CLR_REG    (8'h96),
        .INT_CLR_VAL    (8'hC0)
    ) dut (
        .CLK_I2C     (CLK_I2C),
        .RST_n       (RST_n),
        .HDMI_INT    (HDMI_INT),
        .CONFIG      (CONFIG),
        .config_addr (config_addr),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_done     (wr_done),
        .wr_nack     (wr_nack),
        .ready       (ready),
        .error       (error)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic push_w(input logic [7:0] a, input logic [7:0] d, input bit nack,
                          input int tmode, input bit rdy, input bit err, input bit hold, input bit irq);
        exp_t e;
        e.a = a; e.d = d; e.nack = nack; e.tmode = tmode;
        e.rdy = rdy; e.err = err; e.hold = hold; e.irq = irq;
        expq.push_back(e);
    endtask

    task automatic push_rom(input int i, input bit nack, input int tmode, input bit rdy,
                            input bit err, input bit hold, input bit irq);
        logic [15:0] w;
        w = rom[i];
        push_w(w[15:8], w[7:0], nack, tmode, rdy, err, hold, irq);
    endtask

    // Full ROM walk: entry i is NACKed plan[i] times before it is ACKed
    task automatic push_walk(input int first_mode);
        for (int i = 0; i < NUM; i++) begin
            for (int n = 0; n < plan[i]; n++)
                push_rom(i, 1'b1, (i == 0 && n == 0) ? first_mode : 1, 1'b0, 1'b0, 1'b0, 1'b0);
            push_rom(i, 1'b0, (i == 0 && plan[i] == 0) ? first_mode : 1,
                     (i == NUM - 1), 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic clear_plan();
        for (int i = 0; i < NUM; i++) plan[i] = 0;
    endtask

    // I2C master model and scoreboard monitor
    exp_t cur;
    bit   prev_req, master_busy, last_nack, stray;
    int   last_done_edge, lat;

    initial begin
        done_m = 1'b0; nack_m = 1'b0; int_m = 1'b1;
        prev_req = 1'b0; master_busy = 1'b0; last_nack = 1'b0; last_done_edge = 0;
        forever begin
            @(negedge CLK_I2C);
            if (!RST_n) begin
                prev_req = 1'b0;
            end else if (wr_req && !prev_req) begin
                master_busy = 1'b1;
                stray = (expq.size() == 0);
                if (stray) begin
                    chk("unexpected_write", 32'(wr_req), 32'd0);
                    cur.a = wr_addr; cur.d = wr_data; cur.nack = 1'b0; cur.tmode = 0;
                    cur.rdy = 1'b0; cur.err = 1'b0; cur.hold = 1'b0; cur.irq = 1'b0;
                end else begin
                    cur = expq.pop_front();
                    chk("wr_addr", 32'(wr_addr), 32'(cur.a));
                    chk("wr_data", 32'(wr_data), 32'(cur.d));
                    if (cur.tmode == 2)
                        chk("first_req_edge", edge_cnt, STARTUP + 1);
                    else if (cur.tmode == 1)
                        chk("req_spacing", edge_cnt - last_done_edge, last_nack ? GAP + 1 : 1);
                end
                if (cur.hold) begin
                    prev_req = 1'b1;
                    master_busy = 1'b0;
                end else begin
                    lat = cur.irq ? 6 : int'($urandom_range(1, 4));
                    if (cur.irq) int_m = 1'b0;
                    repeat (lat - 1) @(negedge CLK_I2C);
                    if (!stray) begin
                        chk("req_held", 32'(wr_req), 32'd1);
                        chk("addr_stable", {16'h0, wr_addr, wr_data}, {16'h0, cur.a, cur.d});
                    end
                    done_m = 1'b1; nack_m = cur.nack;
                    @(negedge CLK_I2C);
                    done_m = 1'b0; nack_m = 1'b0; int_m = 1'b1;
                    last_done_edge = edge_cnt;
                    last_nack = cur.nack;
                    chk("req_drop", 32'(wr_req), 32'd0);
                    if (!stray) begin
                        chk("ready_after_write", 32'(ready), 32'(cur.rdy));
                        chk("error_after_write", 32'(error), 32'(cur.err));
                    end
                    prev_req = wr_req;
                    master_busy = 1'b0;
                end
            end else begin
                prev_req = wr_req;
            end
        end
    end

    task automatic wait_idle(input string nm);
        int n = 0;
        while (!(expq.size() == 0 && !master_busy && (ready || error)) && n < BUDGET) begin
            @(negedge CLK_I2C);
            n++;
        end
        chk(nm, 32'(n < BUDGET), 32'd1);
        repeat (5) @(negedge CLK_I2C);
    endtask

    task automatic do_reset();
        @(negedge CLK_I2C);
        #2 RST_n = 1'b0;
        #1;
        chk("rst_wr_req", 32'(wr_req), 32'd0);
        chk("rst_ready",  32'(ready),  32'd0);
        chk("rst_error",  32'(error),  32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        repeat (2) @(negedge CLK_I2C);
        #1 RST_n = 1'b1;
    endtask

    // Falling HDMI_INT: nothing visible after 2 edges, status cleared by edge 4
    task automatic pulse_int(input bit from_done);
        @(negedge CLK_I2C);
        int_s = 1'b0;
        repeat (2) @(negedge CLK_I2C);
        if (from_done) chk("int_ready_before_sync", 32'(ready), 32'd1);
        else           chk("int_error_before_sync", 32'(error), 32'd1);
        repeat (2) @(negedge CLK_I2C);
        if (from_done) chk("int_ready_drop", 32'(ready), 32'd0);
        else           chk("int_error_drop", 32'(error), 32'd0);
        int_s = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        RST_n = 1'b0; int_s = 1'b1; done_s = 1'b0;
        for (int i = 0; i < NUM; i++) rom[i] = 16'($urandom);
        clear_plan();

        repeat (3) @(negedge CLK_I2C);
        chk("init_wr_req", 32'(wr_req), 32'd0);
        chk("init_wr_addr", 32'(wr_addr), 32'd0);
        chk("init_wr_data", 32'(wr_data), 32'd0);
        chk("init_config_addr", 32'(config_addr), 32'd0);
        chk("init_ready", 32'(ready), 32'd0);
        chk("init_error", 32'(error), 32'd0);
        #1 RST_n = 1'b1;

        // All entries acknowledged
        push_walk(2);
        wait_idle("s1_complete");
        @(negedge CLK_I2C); done_s = 1'b1;
        @(negedge CLK_I2C); done_s = 1'b0;
        repeat (3) @(negedge CLK_I2C);
        chk("stray_done_ready", 32'(ready), 32'd1);
        chk("stray_done_error", 32'(error), 32'd0);
        chk("stray_done_index", 32'(config_addr), NUM - 1);
        chk("stray_done_req", 32'(wr_req), 32'd0);

        // Entry 5 NACKed twice then accepted
        do_reset();
        clear_plan();
        plan[5] = 2;
        push_walk(2);
        wait_idle("s2_complete");
        chk("s2_error", 32'(error), 32'd0);

        // Entry 2 exhausts its retries
        do_reset();
        push_rom(0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        push_rom(1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k <= int'(MAXR); k++)
            push_rom(2, 1'b1, 1, 1'b0, (k == int'(MAXR)), 1'b0, 1'b0);
        wait_idle("s3_reach_fail");
        repeat (40) @(negedge CLK_I2C);
        chk("fail_req_low", 32'(wr_req), 32'd0);
        chk("fail_error", 32'(error), 32'd1);
        chk("fail_ready", 32'(ready), 32'd0);
        clear_plan();
        push_w(8'h96, 8'hC0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_walk(1);
        pulse_int(1'b0);
        wait_idle("s3_recover");

        // Interrupt from S_DONE with random NACK pattern on the re-run
        for (int i = 0; i < NUM; i++)
            plan[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, MAXR)) : 0;
        push_w(8'h96, 8'hC0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_walk(1);
        pulse_int(1'b1);
        wait_idle("s4_rerun");

        // Interrupt during entry 7: entry completes, clear write, restart at 0
        do_reset();
        clear_plan();
        for (int i = 0; i < 7; i++) push_rom(i, 1'b0, (i == 0) ? 2 : 1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_rom(7, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1);
        push_w(8'h96, 8'hC0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_walk(1);
        wait_idle("s5_restart");

        // Reset while a write is outstanding
        do_reset();
        for (int i = 0; i < 3; i++) push_rom(i, 1'b0, (i == 0) ? 2 : 1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_rom(3, 1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        n = 0;
        while (!(expq.size() == 0 && wr_req === 1'b1) && n < BUDGET) begin
            @(negedge CLK_I2C);
            n++;
        end
        chk("s6_reach_busy", 32'(n < BUDGET), 32'd1);
        repeat (2) @(negedge CLK_I2C);
        clear_plan();
        do_reset();
        push_walk(2);
        wait_idle("s6_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/adv7513_cfg_sequencer.md
# adv7513_cfg_sequencer

- Sequences the ADV7513 HDMI transmitter bring-up over I2C.
- After reset it waits a power-up delay, then walks the configuration ROM one entry at a time. Each entry is handed to the byte-level I2C write master through a req/done handshake.
- Failed writes (NACK) are retried. A hot-plug or monitor-sense interrupt on HDMI_INT clears the transmitter's interrupt flags and re-runs the full configuration.
- Sits between the config ROM and the I2C master in the clk_src CLK_I2C domain. `ready` gates the HDMI video controller.

## Interface
Parameters:
- NUM_OF_CONFIG, 14: number of ROM entries.
- ADDR_WIDTH, 4: ROM address width; must satisfy 2^ADDR_WIDTH ≥ NUM_OF_CONFIG.
- STARTUP_CYCLES, 50000: power-up wait in CLK_I2C cycles (200 ms at 250 kHz).
- RETRY_GAP, 250: idle cycles between a NACK and the reissue.
- MAX_RETRY, 3: reissues allowed per write before failure.
- INT_CLR_REG, 8'h96: interrupt-clear register address.
- INT_CLR_VAL, 8'hC0: value written to INT_CLR_REG.

Ports:
- CLK_I2C  in  1  block clock. Single clock domain.
- RST_n  in  1  asynchronous, active-low reset.
- HDMI_INT  in  1  ADV7513 interrupt, active-low, asynchronous to CLK_I2C.
- CONFIG  in  16  ROM word at config_addr: {reg_addr[15:8], data[7:0]}. Valid combinationally.
- config_addr  out  ADDR_WIDTH  ROM index.
- wr_req  out  1  write request to the I2C master.
- wr_addr  out  8  register address. Stable while wr_req=1.
- wr_data  out  8  register data. Stable while wr_req=1.
- wr_done  in  1  one-cycle pulse from the master: transaction finished.
- wr_nack  in  1  valid only with wr_done; 1 means the slave NACKed.
- ready  out  1  configuration complete and valid.
- error  out  1  retry limit exhausted.

## Operation
States:
- S_WAIT: startup counter runs.
- S_ISSUE: load wr_addr/wr_data, raise wr_req.
- S_BUSY: hold wr_req until wr_done.
- S_GAP: retry gap counter runs.
- S_DONE: ready=1.
- S_FAIL: error=1.

Transitions:
- Reset → S_WAIT, counter=0, index=0, retry=0, clr_phase=0.
- S_WAIT → S_ISSUE when counter reaches STARTUP_CYCLES-1.
- S_ISSUE:
  - If clr_phase=1: wr_addr=INT_CLR_REG, wr_data=INT_CLR_VAL.
  - Otherwise: wr_addr=CONFIG[15:8], wr_data=CONFIG[7:0], config_addr=index.
  - Next state S_BUSY.
- S_BUSY, wr_done with wr_nack=0:
  - Clear retry.
  - If clr_phase=1: clr_phase←0, index←0, go to S_ISSUE.
  - Else if index=NUM_OF_CONFIG-1: go to S_DONE.
  - Else: index+1, go to S_ISSUE.
- S_BUSY, wr_done with wr_nack=1:
  - If retry<MAX_RETRY: retry+1, go to S_GAP.
  - Else: go to S_FAIL.
- S_GAP → S_ISSUE after RETRY_GAP cycles. The same entry is reissued.
- S_DONE and S_FAIL hold until an interrupt event or reset.

Interrupt event:
- HDMI_INT is synchronised through 2 flip-flops. A falling edge of the synchronised signal sets int_pending.
- In S_WAIT the event is ignored. The full sequence runs anyway.
- In S_DONE or S_FAIL: ready←0, error←0, clr_phase←1, go to S_ISSUE.
- In S_ISSUE, S_BUSY or S_GAP the event stays latched. It is serviced at the next transaction boundary, which is the wr_done cycle or the S_GAP exit:
  - clr_phase←1, retry←0, go to S_ISSUE.
  - The current ROM walk is abandoned; the walk restarts from index 0 after the clear write.
- A second event while int_pending is already set merges with the first.

## Timing
- Reset values: wr_req=0, wr_addr=0, wr_data=0, config_addr=0, ready=0, error=0.
- All outputs are registered.
- First wr_req rises STARTUP_CYCLES+1 rising edges after RST_n deasserts.
- wr_req falls on the edge after wr_done. The next wr_req rises 2 edges after wr_done, with no NACK and no gap.
- NACK to reissued wr_req: RETRY_GAP+2 cycles.
- ready rises on the edge after the final successful wr_done.
- HDMI_INT fall to ready=0: 3–4 edges (2 sync + edge detect + register) when in S_DONE.
- RST_n assertion mid-transaction drops wr_req immediately. The master must abort on its own reset.
- wr_done arriving outside S_BUSY is ignored.
- Counter widths use $clog2 of the maximum count. No counter wraps; each is cleared on state entry.

## Structure
- Shared package adv7513_cfg_pkg holds:
  - the state enum;
  - default INT_CLR_REG/INT_CLR_VAL constants;
  - the {reg, data} field slice positions.
- One sub-module, int_sync_edge: 2-flip-flop synchroniser plus falling-edge pulse. It is reused for other asynchronous status pins.

## Test plan
- STARTUP_CYCLES=10, 14 entries, all ACK → first wr_req at edge 11; exactly 14 writes whose wr_addr/wr_data match the ROM in order; ready=1 the edge after the 14th wr_done.
- NACK on entry 5 twice, then ACK → entry 5 issued 3 times, each reissue RETRY_GAP+2 cycles after its NACK; entries 6–13 follow; ready=1, error=0.
- Entry 2 NACKed 4 times (MAX_RETRY=3) → error=1, ready=0, wr_req stays 0; a later HDMI_INT fall clears error and issues write 0x96=0xC0, then entries 0–13.
- HDMI_INT pulse low in S_DONE → ready=0 within 4 edges; clear write 0x96/0xC0, then 14 ROM writes; ready=1.
- HDMI_INT fall during entry 7's S_BUSY → entry 7 completes; next write is 0x96/0xC0, then ROM restarts from index 0 (not 8).
- RST_n low during S_BUSY → wr_req/ready/error=0 asynchronously; after release the sequence restarts from S_WAIT.
